// File: rtl/vip_fci_pkg.sv
// Shared control-field types for the VIP input stages (width/height/interlace shadowing).
// Latency: none. This is a types-only package.
// Backpressure: not applicable.
package vip_fci_pkg;

    localparam int CTRL_W = 36;

    // Control-packet fields as one word, so shadow and committed copies move together.
    typedef struct packed {
        logic [15:0] width;
        logic [15:0] height;
        logic [3:0]  interlaced;
    } vip_ctrl_t;

endpackage

// File: rtl/vip_fci_fifo.sv
// Generic first-word-fall-through FIFO with a registered head word and an occupancy count.
// Latency: a write into an empty FIFO is visible on rd_data one cycle later.
// Backpressure: writes are ignored when full and reads are ignored when empty; the caller gates on count.
// Ports: clk/rst (async, active-high), wr_en/wr_data, rd_en/rd_data (head word), count [ADDR_W:0].
module vip_fci_fifo #(
    parameter int WIDTH = 25,
    parameter int DEPTH = 4,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic              rd_en,
    output logic [WIDTH-1:0]  rd_data,
    output logic [ADDR_W:0]   count
);

    localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] ONE_CNT  = (ADDR_W+1)'(1);

    logic [WIDTH-1:0]  mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W-1:0] rd_ptr_nxt;
    logic              do_wr;
    logic              do_rd;

    assign do_wr      = wr_en & (count != FULL_CNT);
    assign do_rd      = rd_en & (count != '0);
    assign rd_ptr_nxt = rd_ptr + 1'b1;

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // The head is kept in its own register so the consumer sees a clean
    // flop output rather than a read mux that moves with rd_ptr.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            rd_data <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_rd) begin
                rd_ptr <= rd_ptr_nxt;
            end
            if (do_wr && !do_rd) begin
                count <= count + 1'b1;
            end else if (!do_wr && do_rd) begin
                count <= count - 1'b1;
            end
            // The incoming word becomes head when the FIFO is, or is about to be, otherwise empty.
            if (do_wr && ((count == '0) || (do_rd && (count == ONE_CNT)))) begin
                rd_data <= wr_data;
            end else if (do_rd && (count > ONE_CNT)) begin
                rd_data <= mem[rd_ptr_nxt];
            end
        end
    end

endmodule

// File: rtl/vip_flow_control_input_fifo.sv
// Decoder-to-core input stage: drops non-video beats, buffers video beats, and commits control fields once the video beats ahead of them have drained.
// Latency: one cycle from an accepted video beat to data_in when the FIFO is empty. Control commit happens one cycle after FIFO-empty with no write.
// Backpressure: din_ready falls only for video beats when the FIFO is full. Non-video beats are always taken. The core sees stall_in = empty.
// Ports: clk/rst (async, active-high); decoder side din_*/decoder_*; core side data_in, end_of_video_in, width_in/height_in/interlaced_in, vip_ctrl_valid_in, read, stall_in.
// Optional: define VIP_FCI_FILL_LEVEL_EN to add fill_level (current count) and max_fill (sticky high-watermark).
module vip_flow_control_input_fifo
    import vip_fci_pkg::*;
#(
    parameter int BITS_PER_SYMBOL  = 8,
    parameter int SYMBOLS_PER_BEAT = 3,
    parameter int DEPTH            = 4,
    localparam int DATA_W = BITS_PER_SYMBOL * SYMBOLS_PER_BEAT,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    output logic              din_ready,
    input  logic              din_valid,
    input  logic [DATA_W-1:0] din_data,
    input  logic              decoder_end_of_video,
    input  logic              decoder_is_video,
    input  logic [15:0]       decoder_width,
    input  logic [15:0]       decoder_height,
    input  logic [3:0]        decoder_interlaced,
    input  logic              decoder_vip_ctrl_valid,
    output logic [DATA_W-1:0] data_in,
    output logic              end_of_video_in,
    output logic [15:0]       width_in,
    output logic [15:0]       height_in,
    output logic [3:0]        interlaced_in,
    output logic              vip_ctrl_valid_in,
    input  logic              read,
    output logic              stall_in
`ifdef VIP_FCI_FILL_LEVEL_EN
    ,
    output logic [ADDR_W:0]   fill_level,
    output logic [ADDR_W:0]   max_fill
`endif
);

    localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);

    logic [DATA_W:0]  head;
    logic [ADDR_W:0]  count;
    logic             full;
    logic             empty;
    logic             wr;
    logic             pop;
    logic             commit;
    logic             pending;
    vip_ctrl_t        shadow;

    assign full      = (count == FULL_CNT);
    assign empty     = (count == '0);
    assign din_ready = ~decoder_is_video | ~full;
    assign stall_in  = empty;
    assign wr        = din_valid & decoder_is_video & ~full;
    assign pop       = read & ~empty;
    // The control fields apply to the next frame. They are held back while any video
    // beat is in flight, including a beat that is being written this cycle.
    assign commit    = pending & empty & ~wr;

    vip_fci_fifo #(
        .WIDTH (DATA_W + 1),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr),
        .wr_data ({decoder_end_of_video, din_data}),
        .rd_en   (pop),
        .rd_data (head),
        .count   (count)
    );

    assign data_in         = head[DATA_W-1:0];
    assign end_of_video_in = head[DATA_W];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow            <= '0;
            pending           <= 1'b0;
            width_in          <= '0;
            height_in         <= '0;
            interlaced_in     <= '0;
            vip_ctrl_valid_in <= 1'b0;
        end else begin
            vip_ctrl_valid_in <= commit;
            if (commit) begin
                width_in      <= shadow.width;
                height_in     <= shadow.height;
                interlaced_in <= shadow.interlaced;
                pending       <= 1'b0;
            end
            // This branch comes last, so a pulse in the commit cycle stays pending for a later commit.
            if (decoder_vip_ctrl_valid) begin
                shadow  <= '{width: decoder_width, height: decoder_height,
                             interlaced: decoder_interlaced};
                pending <= 1'b1;
            end
        end
    end

`ifdef VIP_FCI_FILL_LEVEL_EN
    assign fill_level = count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            max_fill <= '0;
        end else if (count > max_fill) begin
            max_fill <= count;
        end
    end
`endif

endmodule
